// File: rtl/mem_lsu_pkg.sv
// mem_lsu_pkg
//   Shared constants and helpers for the RiSC16 load/store unit.
//   WORD_LEN     : data word width
//   ADDR_LEN     : address width
//   SB_DEPTH_DEF : default store-buffer depth (power of two, >= 2)
//   addr_adjacent(): true when a buffered store at entry_addr overlaps a
//                    word load at req_addr by exactly one byte cell.
package mem_lsu_pkg;

  localparam int WORD_LEN     = 16;
  localparam int ADDR_LEN     = 16;
  localparam int SB_DEPTH_DEF = 4;

  // A store at A writes cells A and A+1, a load at L reads L and L+1, so the
  // two overlap partially when A is L-1 or L+1 (modulo the address space).
  function automatic logic addr_adjacent(input logic [ADDR_LEN-1:0] entry_addr,
                                         input logic [ADDR_LEN-1:0] req_addr);
    logic [ADDR_LEN-1:0] up;
    logic [ADDR_LEN-1:0] dn;
    up = req_addr + ADDR_LEN'(1);
    dn = req_addr - ADDR_LEN'(1);
    return (entry_addr == up) || (entry_addr == dn);
  endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// mem_lsu_if
//   Bundles the datapath request/response handshake and the mem_data
//   read/write port signals of the load/store unit.
//   modport slave  : the LSU side (mem_lsu)
//   modport master : the datapath/controller plus mem_data side
interface mem_lsu_if;
  import mem_lsu_pkg::*;

  // datapath request / response
  logic                reqValid;
  logic                reqReady;
  logic                reqWe;
  logic [ADDR_LEN-1:0] reqAddr;
  logic [WORD_LEN-1:0] reqData;
  logic                respValid;
  logic [WORD_LEN-1:0] respData;
  // mem_data ports
  logic [ADDR_LEN-1:0] memReadAddr;
  logic [WORD_LEN-1:0] memDataOut;
  logic [ADDR_LEN-1:0] memWrAddr;
  logic [WORD_LEN-1:0] memDataIn;
  logic                memWriteEn;
  logic                memHold;
  // controller status
  logic                sbEmpty;

  modport slave (
    input  reqValid, reqWe, reqAddr, reqData, memDataOut, memHold,
    output reqReady, respValid, respData, memReadAddr, memWrAddr,
           memDataIn, memWriteEn, sbEmpty
  );

  modport master (
    output reqValid, reqWe, reqAddr, reqData, memDataOut, memHold,
    input  reqReady, respValid, respData, memReadAddr, memWrAddr,
           memDataIn, memWriteEn, sbEmpty
  );

endinterface

// File: rtl/lsu_store_fifo.sv
// lsu_store_fifo
//   Circular store buffer for mem_lsu. Holds {addr,data} entries, exposes
//   the head entry for draining and a per-entry valid (and, with
//   LSU_STORE_FWD_EN defined, data/age) view for the load hazard compare.
//   Ports: clk, rst (async, active-high), push/push_addr/push_data (enqueue),
//          pop (dequeue head), full, empty, head_addr, head_data,
//          ent_valid, ent_addr, [ent_data, ent_age when LSU_STORE_FWD_EN].
//   Age 0 is the oldest (head) entry; larger age means younger.
module lsu_store_fifo
  import mem_lsu_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  logic [ADDR_LEN-1:0] push_addr,
  input  logic [WORD_LEN-1:0] push_data,
  input  logic                pop,
  output logic                full,
  output logic                empty,
  output logic [ADDR_LEN-1:0] head_addr,
  output logic [WORD_LEN-1:0] head_data,
  output logic [DEPTH-1:0]    ent_valid,
  output logic [ADDR_LEN-1:0] ent_addr [DEPTH]
`ifdef LSU_STORE_FWD_EN
  ,
  output logic [WORD_LEN-1:0]        ent_data [DEPTH],
  output logic [$clog2(DEPTH)-1:0]   ent_age  [DEPTH]
`endif
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]    count;
  logic [ADDR_LEN-1:0] addr_mem [DEPTH];
  logic [WORD_LEN-1:0] data_mem [DEPTH];

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Entry storage needs no reset: every read of it is qualified by valid.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr_q[IDX_W-1:0]] <= push_addr;
      data_mem[wr_ptr_q[IDX_W-1:0]] <= push_data;
    end
  end

  assign count     = wr_ptr_q - rd_ptr_q;
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]) &&
                     (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
  assign head_addr = addr_mem[rd_ptr_q[IDX_W-1:0]];
  assign head_data = data_mem[rd_ptr_q[IDX_W-1:0]];

  // Slot age is its distance from the head; it is live if that distance is
  // below the current occupancy.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
    logic [IDX_W-1:0] age;
    assign age           = IDX_W'(gi) - rd_ptr_q[IDX_W-1:0];
    assign ent_valid[gi] = (PTR_W'(age) < count);
    assign ent_addr[gi]  = addr_mem[gi];
`ifdef LSU_STORE_FWD_EN
    assign ent_data[gi]  = data_mem[gi];
    assign ent_age[gi]   = age;
`endif
  end

endmodule

// File: rtl/mem_lsu.sv
// mem_lsu
//   Load/store unit between the RiSC16 datapath and mem_data. Loads read
//   mem_data combinationally and respond one cycle after acceptance; stores
//   are queued in lsu_store_fifo and drained whenever memHold is low.
//   Ports: clk, rst (async, active-high), bus (mem_lsu_if.slave: request,
//          response, mem_data read/write ports, memHold, sbEmpty).
//   Config: define LSU_STORE_FWD_EN to forward the youngest exactly matching
//           buffered store to a load instead of stalling it. Partial
//           overlaps always stall.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int SB_DEPTH = SB_DEPTH_DEF
) (
  input logic      clk,
  input logic      rst,
  mem_lsu_if.slave bus
);

  logic                sb_push, sb_pop, sb_full, sb_empty;
  logic [ADDR_LEN-1:0] head_addr;
  logic [WORD_LEN-1:0] head_data;
  logic [SB_DEPTH-1:0] ent_valid;
  logic [ADDR_LEN-1:0] ent_addr [SB_DEPTH];
`ifdef LSU_STORE_FWD_EN
  logic [WORD_LEN-1:0]          ent_data [SB_DEPTH];
  logic [$clog2(SB_DEPTH)-1:0]  ent_age  [SB_DEPTH];
  logic [$clog2(SB_DEPTH)-1:0]  fwd_age;
  logic                         fwd_found;
  logic [WORD_LEN-1:0]          fwd_data;
`endif

  logic                exact_hit, partial_hit, load_stall, load_fire;
  logic [WORD_LEN-1:0] load_data;
  logic                resp_valid_q, resp_valid_d;
  logic [WORD_LEN-1:0] resp_data_q, resp_data_d;

  lsu_store_fifo #(.DEPTH(SB_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (sb_push),
    .push_addr (bus.reqAddr),
    .push_data (bus.reqData),
    .pop       (sb_pop),
    .full      (sb_full),
    .empty     (sb_empty),
    .head_addr (head_addr),
    .head_data (head_data),
    .ent_valid (ent_valid),
    .ent_addr  (ent_addr)
`ifdef LSU_STORE_FWD_EN
    ,
    .ent_data  (ent_data),
    .ent_age   (ent_age)
`endif
  );

  // Hazard compare covers every live entry, including the head that may be
  // draining this very cycle: its write lands only at the coming edge.
  always_comb begin
    exact_hit   = 1'b0;
    partial_hit = 1'b0;
`ifdef LSU_STORE_FWD_EN
    fwd_found   = 1'b0;
    fwd_age     = '0;
    fwd_data    = '0;
`endif
    for (int i = 0; i < SB_DEPTH; i++) begin
      if (ent_valid[i]) begin
        if (ent_addr[i] == bus.reqAddr) begin
          exact_hit = 1'b1;
`ifdef LSU_STORE_FWD_EN
          if (!fwd_found || (ent_age[i] > fwd_age)) begin
            fwd_found = 1'b1;
            fwd_age   = ent_age[i];
            fwd_data  = ent_data[i];
          end
`endif
        end
        if (addr_adjacent(ent_addr[i], bus.reqAddr)) partial_hit = 1'b1;
      end
    end
`ifdef LSU_STORE_FWD_EN
    load_stall = partial_hit;
    load_data  = exact_hit ? fwd_data : bus.memDataOut;
`else
    load_stall = partial_hit || exact_hit;
    load_data  = bus.memDataOut;
`endif
  end

  always_comb begin
    // A full buffer refuses stores even if the head drains this cycle.
    sb_push      = bus.reqValid && bus.reqWe && !sb_full;
    sb_pop       = !sb_empty && !bus.memHold;
    load_fire    = bus.reqValid && !bus.reqWe && !load_stall;
    resp_valid_d = load_fire;
    resp_data_d  = load_fire ? load_data : resp_data_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
    end
  end

  assign bus.reqReady    = bus.reqWe ? !sb_full : !load_stall;
  assign bus.respValid   = resp_valid_q;
  assign bus.respData    = resp_data_q;
  assign bus.memReadAddr = bus.reqAddr;
  assign bus.memWriteEn  = sb_pop;
  // Head contents are stale when empty; present zeros instead.
  assign bus.memWrAddr   = sb_empty ? '0 : head_addr;
  assign bus.memDataIn   = sb_empty ? '0 : head_data;
  assign bus.sbEmpty     = sb_empty;

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu
//   Self-checking bench for mem_lsu: a per-cycle vector table plus
//   hand-written sequences for store-to-load, youngest-wins and reset
//   mid-drain. mem_data is modelled as a byte-cell memory whose unwritten
//   cells read back as the low byte of their own address.
//   Honours LSU_STORE_FWD_EN when choosing expected stall counts.
module tb_mem_lsu;
  import mem_lsu_pkg::*;

`ifdef LSU_STORE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_lsu_if bus ();

  mem_lsu dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- mem_data model ----------------
  bit [7:0]    mem_q  [65536];
  bit          seen_q [65536];
  logic [15:0] ra1, wa1;
  int          n_writes = 0;

  assign ra1 = bus.memReadAddr + 16'd1;
  assign wa1 = bus.memWrAddr + 16'd1;
  assign bus.memDataOut = {seen_q[bus.memReadAddr] ? mem_q[bus.memReadAddr] : bus.memReadAddr[7:0],
                           seen_q[ra1] ? mem_q[ra1] : ra1[7:0]};

  always @(posedge clk) begin
    if (bus.memWriteEn === 1'b1) begin
      mem_q[bus.memWrAddr]  <= bus.memDataIn[15:8];
      seen_q[bus.memWrAddr] <= 1'b1;
      mem_q[wa1]            <= bus.memDataIn[7:0];
      seen_q[wa1]           <= 1'b1;
      n_writes              <= n_writes + 1;
    end
  end

  // ---------------- checking ----------------
  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input bit v, input bit we, input bit [15:0] a, input bit [15:0] d, input bit h);
    bus.reqValid = v;
    bus.reqWe    = we;
    bus.reqAddr  = a;
    bus.reqData  = d;
    bus.memHold  = h;
  endtask

  typedef struct {
    bit        v;
    bit        we;
    bit [15:0] addr;
    bit [15:0] data;
    bit        hold;
    bit        e_ready;
    bit        e_wen;
    bit        e_empty;
    bit [15:0] e_waddr;
    bit        e_rv;
    bit [15:0] e_rd;
  } vec_t;

  function automatic vec_t mk(bit v, bit we, bit [15:0] a, bit [15:0] d, bit h,
                              bit rdy, bit wen, bit emp, bit [15:0] wa, bit rv, bit [15:0] rd);
    vec_t r;
    r.v = v; r.we = we; r.addr = a; r.data = d; r.hold = h;
    r.e_ready = rdy; r.e_wen = wen; r.e_empty = emp; r.e_waddr = wa;
    r.e_rv = rv; r.e_rd = rd;
    return r;
  endfunction

  // Issue a load, hold memHold high for the first hold_cycles attempts,
  // count stall cycles, then check the one-cycle response pulse.
  task automatic load_wait(input string nm, input bit [15:0] a, input int hold_cycles,
                           input int exp_stalls, input bit [15:0] exp_data);
    int  stalls;
    bit  done;
    stalls = 0;
    done   = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(posedge clk); #1;
      drive(1'b1, 1'b0, a, 16'h0000, c < hold_cycles);
      @(negedge clk);
      if (bus.reqReady) done = 1'b1;
      else stalls++;
    end
    chk({nm, "_accepted"}, 32'(done), 32'd1);
    chk({nm, "_stalls"}, 32'(stalls), 32'(exp_stalls));
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    @(negedge clk);
    chk({nm, "_resp_valid"}, 32'(bus.respValid), 32'd1);
    chk({nm, "_resp_data"}, 32'(bus.respData), 32'(exp_data));
    @(posedge clk); #1;
    @(negedge clk);
    chk({nm, "_resp_pulse"}, 32'(bus.respValid), 32'd0);
    $display("load %h: stalls=%0d data=%h", a, stalls, bus.respData);
  endtask

  vec_t vt[$];

  initial begin
    // Per-cycle table: inputs for the cycle, outputs seen mid-cycle.
    //            v  we addr      data      h   rdy wen emp waddr     rv rd
    vt.push_back(mk(0, 0, 16'h0000, 16'h0000, 0,  1, 0, 1, 16'h0000, 0, 16'h0000));
    vt.push_back(mk(1, 0, 16'h0100, 16'h0000, 0,  1, 0, 1, 16'h0000, 0, 16'h0000));
    vt.push_back(mk(1, 0, 16'h0155, 16'h0000, 0,  1, 0, 1, 16'h0000, 1, 16'h0001));
    vt.push_back(mk(0, 0, 16'h0000, 16'h0000, 0,  1, 0, 1, 16'h0000, 1, 16'h5556));
    // full buffer under memHold, then ordered drain
    vt.push_back(mk(1, 1, 16'h0020, 16'hA020, 1,  1, 0, 1, 16'h0000, 0, 16'h5556));
    vt.push_back(mk(1, 1, 16'h0022, 16'hA022, 1,  1, 0, 0, 16'h0000, 0, 16'h5556));
    vt.push_back(mk(1, 1, 16'h0024, 16'hA024, 1,  1, 0, 0, 16'h0000, 0, 16'h5556));
    vt.push_back(mk(1, 1, 16'h0026, 16'hA026, 1,  1, 0, 0, 16'h0000, 0, 16'h5556));
    vt.push_back(mk(1, 1, 16'h0028, 16'hA028, 1,  0, 0, 0, 16'h0000, 0, 16'h5556));
    vt.push_back(mk(1, 1, 16'h0028, 16'hA028, 0,  0, 1, 0, 16'h0020, 0, 16'h5556));
    vt.push_back(mk(1, 1, 16'h0028, 16'hA028, 0,  1, 1, 0, 16'h0022, 0, 16'h5556));
    vt.push_back(mk(0, 0, 16'h0000, 16'h0000, 0,  1, 1, 0, 16'h0024, 0, 16'h5556));
    vt.push_back(mk(0, 0, 16'h0000, 16'h0000, 0,  1, 1, 0, 16'h0026, 0, 16'h5556));
    vt.push_back(mk(0, 0, 16'h0000, 16'h0000, 0,  1, 1, 0, 16'h0028, 0, 16'h5556));
    vt.push_back(mk(0, 0, 16'h0000, 16'h0000, 0,  1, 0, 1, 16'h0000, 0, 16'h5556));
    vt.push_back(mk(1, 0, 16'h0022, 16'h0000, 0,  1, 0, 1, 16'h0000, 0, 16'h5556));
    vt.push_back(mk(1, 0, 16'h0027, 16'h0000, 0,  1, 0, 1, 16'h0000, 1, 16'hA022));
    vt.push_back(mk(0, 0, 16'h0000, 16'h0000, 0,  1, 0, 1, 16'h0000, 1, 16'h26A0));
    // partial overlap: SW 0x30, LW 0x31
    vt.push_back(mk(1, 1, 16'h0030, 16'h1234, 1,  1, 0, 1, 16'h0000, 0, 16'h26A0));
    vt.push_back(mk(1, 0, 16'h0031, 16'h0000, 1,  0, 0, 0, 16'h0000, 0, 16'h26A0));
    vt.push_back(mk(1, 0, 16'h0031, 16'h0000, 1,  0, 0, 0, 16'h0000, 0, 16'h26A0));
    vt.push_back(mk(1, 0, 16'h0031, 16'h0000, 0,  0, 1, 0, 16'h0030, 0, 16'h26A0));
    vt.push_back(mk(1, 0, 16'h0031, 16'h0000, 0,  1, 0, 1, 16'h0000, 0, 16'h26A0));
    vt.push_back(mk(0, 0, 16'h0000, 16'h0000, 0,  1, 0, 1, 16'h0000, 1, 16'h3432));
    // address wrap: SW 0xFFFF, LW 0x0000
    vt.push_back(mk(1, 1, 16'hFFFF, 16'h5A5A, 1,  1, 0, 1, 16'h0000, 0, 16'h3432));
    vt.push_back(mk(1, 0, 16'h0000, 16'h0000, 1,  0, 0, 0, 16'h0000, 0, 16'h3432));
    vt.push_back(mk(1, 0, 16'h0000, 16'h0000, 0,  0, 1, 0, 16'hFFFF, 0, 16'h3432));
    vt.push_back(mk(1, 0, 16'h0000, 16'h0000, 0,  1, 0, 1, 16'h0000, 0, 16'h3432));
    vt.push_back(mk(0, 0, 16'h0000, 16'h0000, 0,  1, 0, 1, 16'h0000, 1, 16'h5A01));
    // hazard-free loads proceed while memHold blocks draining
    vt.push_back(mk(1, 1, 16'h0050, 16'h7777, 1,  1, 0, 1, 16'h0000, 0, 16'h5A01));
    vt.push_back(mk(1, 0, 16'h0060, 16'h0000, 1,  1, 0, 0, 16'h0000, 0, 16'h5A01));
    vt.push_back(mk(1, 0, 16'h0052, 16'h0000, 1,  1, 0, 0, 16'h0000, 1, 16'h6061));
    vt.push_back(mk(0, 0, 16'h0000, 16'h0000, 0,  1, 1, 0, 16'h0050, 1, 16'h5253));
    vt.push_back(mk(0, 0, 16'h0000, 16'h0000, 0,  1, 0, 1, 16'h0000, 0, 16'h5253));

    // ---------------- reset state ----------------
    drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_reqReady",   32'(bus.reqReady),   32'd1);
    chk("rst_respValid",  32'(bus.respValid),  32'd0);
    chk("rst_respData",   32'(bus.respData),   32'd0);
    chk("rst_memWriteEn", 32'(bus.memWriteEn), 32'd0);
    chk("rst_memWrAddr",  32'(bus.memWrAddr),  32'd0);
    chk("rst_memDataIn",  32'(bus.memDataIn),  32'd0);
    chk("rst_sbEmpty",    32'(bus.sbEmpty),    32'd1);

    // ---------------- table ----------------
    for (int i = 0; i < vt.size(); i++) begin
      @(posedge clk); #1;
      drive(vt[i].v, vt[i].we, vt[i].addr, vt[i].data, vt[i].hold);
      @(negedge clk);
      chk($sformatf("row%0d_reqReady", i),   32'(bus.reqReady),   32'(vt[i].e_ready));
      chk($sformatf("row%0d_memWriteEn", i), 32'(bus.memWriteEn), 32'(vt[i].e_wen));
      chk($sformatf("row%0d_sbEmpty", i),    32'(bus.sbEmpty),    32'(vt[i].e_empty));
      if (vt[i].e_wen)
        chk($sformatf("row%0d_memWrAddr", i), 32'(bus.memWrAddr), 32'(vt[i].e_waddr));
      chk($sformatf("row%0d_respValid", i),  32'(bus.respValid),  32'(vt[i].e_rv));
      chk($sformatf("row%0d_respData", i),   32'(bus.respData),   32'(vt[i].e_rd));
      $display("row %0d: v=%0b we=%0b addr=%h data=%h hold=%0b -> rdy=%0b wen=%0b empty=%0b rv=%0b rd=%h",
               i, vt[i].v, vt[i].we, vt[i].addr, vt[i].data, vt[i].hold,
               bus.reqReady, bus.memWriteEn, bus.sbEmpty, bus.respValid, bus.respData);
    end

    // ---------------- store then load to the same address ----------------
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 16'h0010, 16'hBEEF, 1'b0);
    @(negedge clk);
    chk("st_ld_store_ready", 32'(bus.reqReady), 32'd1);
    load_wait("st_ld", 16'h0010, 0, FWD ? 0 : 1, 16'hBEEF);

    // ---------------- youngest store wins ----------------
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 16'h0040, 16'h1111, 1'b1);
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 16'h0040, 16'h2222, 1'b1);
    @(negedge clk);
    chk("young_store_ready", 32'(bus.reqReady), 32'd1);
    load_wait("young", 16'h0040, 3, FWD ? 0 : 5, 16'h2222);
    begin
      bit drained;
      drained = 1'b0;
      for (int c = 0; c < 10 && !drained; c++) begin
        @(negedge clk);
        if (bus.sbEmpty) drained = 1'b1;
      end
      chk("young_drained", 32'(drained), 32'd1);
    end

    // ---------------- reset while stores are pending ----------------
    begin
      int w0;
      for (int k = 0; k < 3; k++) begin
        @(posedge clk); #1;
        drive(1'b1, 1'b1, 16'(16'h0070 + 2 * k), 16'(16'hD070 + 2 * k), 1'b1);
      end
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
      @(negedge clk);
      chk("rstmid_pending", 32'(bus.sbEmpty), 32'd0);
      #2;
      rst = 1'b1;
      bus.memHold = 1'b0;
      #1;
      chk("rstmid_sbEmpty",    32'(bus.sbEmpty),    32'd1);
      chk("rstmid_memWriteEn", 32'(bus.memWriteEn), 32'd0);
      chk("rstmid_memWrAddr",  32'(bus.memWrAddr),  32'd0);
      chk("rstmid_respData",   32'(bus.respData),   32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      w0 = n_writes;
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("rstmid_no_writes", 32'(n_writes - w0), 32'd0);
      chk("rstmid_cell70",    32'(seen_q[16'h0070]), 32'd0);
      chk("rstmid_sbEmpty2",  32'(bus.sbEmpty),    32'd1);
      $display("reset mid-drain: writes after release=%0d", n_writes - w0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
